// File: rtl/imem_pkg.sv
// Shared types and constants for the program instruction memory.
package imem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } ld_state_t;

  localparam logic [63:0] NOP_DEFAULT = '0;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM with write enable and registered read.
module imem_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read data register only moves on a read, so it holds between fetches.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/prog_imem.sv
// Program instruction memory: burst loader FSM plus 1-cycle fetch port
// with stall hold and out-of-range detection.
module prog_imem
  import imem_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 16,
  parameter int              DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch,
  input  logic              stall,
  output logic [DATA_W-1:0] op,
  output logic              op_valid,
  output logic              op_err,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_busy,
  output logic              ld_done
);

  localparam int              RA_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  ld_state_t         state;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   ld_last;
  logic [ADDR_W:0]   eff_len;
  logic              in_range;
  logic              op_nop;
  logic              wr_en;
  logic              rd_en;
  logic [RA_W-1:0]   ram_addr;
  logic [DATA_W-1:0] rd_data;

  assign eff_len  = (ld_len > DEPTH_L) ? DEPTH_L : ld_len;
  assign in_range = {1'b0, pc} < DEPTH_L;

  // The port is owned by the loader in LOAD and by the fetch side in IDLE,
  // so reads and writes never collide.
  assign wr_en    = !rst && (state == LOAD) && ld_valid;
  assign rd_en    = !rst && !stall && fetch && (state == IDLE) && in_range;
  assign ram_addr = (state == LOAD) ? wr_ptr[RA_W-1:0] : pc[RA_W-1:0];

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (ram_addr),
    .wdata (ld_data),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      ld_last <= '0;
      ld_busy <= 1'b0;
      ld_done <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            if (eff_len == '0) begin
              ld_done <= 1'b1;
            end else begin
              state   <= LOAD;
              ld_busy <= 1'b1;
              wr_ptr  <= '0;
              ld_last <= eff_len - ONE;
            end
          end
        end
        LOAD: begin
          if (ld_valid) begin
            wr_ptr <= wr_ptr + ONE;
            if (wr_ptr == ld_last) begin
              state   <= IDLE;
              ld_busy <= 1'b0;
              ld_done <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ld_busy <= 1'b0;
        end
      endcase
    end
  end

  // op_nop selects NOP_WORD over the RAM read register; both only change
  // on an accepted fetch, which keeps op stable across idle and stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_nop   <= 1'b1;
      op_valid <= 1'b0;
      op_err   <= 1'b0;
    end else if (!stall) begin
      if (fetch && (state == IDLE)) begin
        op_valid <= 1'b1;
        op_err   <= !in_range;
        op_nop   <= !in_range;
      end else begin
        op_valid <= 1'b0;
      end
    end
  end

  assign op = op_nop ? NOP_WORD : rd_data;

endmodule

// File: tb/tb_prog_imem.sv
// Scoreboard bench for prog_imem: fetch expectations are queued by the
// stimulus and popped by a monitor whenever op_valid is presented.
module tb_prog_imem;

  localparam int          ADDR_W = 8;
  localparam int          DATA_W = 16;
  localparam int          DEPTH  = 32;
  localparam logic [15:0] NOP    = 16'hF00F;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc;
  logic              fetch;
  logic              stall;
  logic [DATA_W-1:0] op;
  logic              op_valid;
  logic              op_err;
  logic              ld_start;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_busy;
  logic              ld_done;

  typedef struct {
    logic [15:0] op;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic        vpat [64];
  logic [15:0] dpat [64];

  prog_imem #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .fetch    (fetch),
    .stall    (stall),
    .op       (op),
    .op_valid (op_valid),
    .op_err   (op_err),
    .ld_start (ld_start),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && op_valid) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: op=%h err=%b with nothing expected", op, op_err);
      end else begin
        e = q.pop_front();
        if (op !== e.op || op_err !== e.err) begin
          errors++;
          $display("FAIL fetch: got op=%h err=%b, expected op=%h err=%b", op, op_err, e.op, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fetch_at(input logic [7:0] a, input logic [15:0] e_op, input logic e_err);
    exp_t e;
    e.op  = e_op;
    e.err = e_err;
    fetch = 1'b1;
    pc    = a;
    q.push_back(e);
    tick();
    fetch = 1'b0;
  endtask

  // Burst of len_in words driven over ncyc cycles from vpat/dpat.
  task automatic load(input int len_in, input int ncyc);
    int exp_len;
    int writes;
    exp_len  = (len_in > DEPTH) ? DEPTH : len_in;
    writes   = 0;
    ld_start = 1'b1;
    ld_len   = (ADDR_W+1)'(len_in);
    tick();
    ld_start = 1'b0;
    if (exp_len == 0) begin
      chk("zero_len_done", ld_done, 1);
      chk("zero_len_busy", ld_busy, 0);
    end else begin
      chk("start_busy", ld_busy, 1);
    end
    for (int c = 0; c < ncyc; c++) begin
      ld_valid = vpat[c];
      ld_data  = dpat[c];
      tick();
      if (vpat[c]) writes++;
      if (vpat[c] && writes == exp_len) begin
        chk("last_done", ld_done, 1);
        chk("last_busy", ld_busy, 0);
      end else begin
        chk("mid_busy", ld_busy, 1);
        chk("mid_done", ld_done, 0);
      end
    end
    ld_valid = 1'b0;
    tick();
    chk("done_one_cycle", ld_done, 0);
  endtask

  initial begin
    rst = 1'b1; pc = '0; fetch = 1'b0; stall = 1'b0;
    ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    tick(); tick();
    chk("rst_op", op, NOP);
    chk("rst_valid", op_valid, 0);
    chk("rst_err", op_err, 0);
    chk("rst_busy", ld_busy, 0);
    chk("rst_done", ld_done, 0);
    rst = 1'b0;
    tick();

    // Four-word burst, continuous valid
    vpat[0] = 1; dpat[0] = 16'h5005;
    vpat[1] = 1; dpat[1] = 16'h6016;
    vpat[2] = 1; dpat[2] = 16'h2102;
    vpat[3] = 1; dpat[3] = 16'h4301;
    load(4, 4);
    fetch_at(0, 16'h5005, 0);
    fetch_at(1, 16'h6016, 0);
    fetch_at(2, 16'h2102, 0);
    fetch_at(3, 16'h4301, 0);
    tick();
    chk("idle_valid", op_valid, 0);
    chk("idle_hold_op", op, 16'h4301);

    // Burst with valid gaps: 1,0,0,1,1 for three words
    vpat[0] = 1; dpat[0] = 16'h1111;
    vpat[1] = 0; dpat[1] = 16'hBAD0;
    vpat[2] = 0; dpat[2] = 16'hBAD1;
    vpat[3] = 1; dpat[3] = 16'h2222;
    vpat[4] = 1; dpat[4] = 16'h3333;
    load(3, 5);
    fetch_at(0, 16'h1111, 0);
    fetch_at(1, 16'h2222, 0);
    fetch_at(2, 16'h3333, 0);
    fetch_at(3, 16'h4301, 0);

    // Out-of-range fetches then back in range
    fetch_at(40, NOP, 1);
    fetch_at(3, 16'h4301, 0);
    fetch_at(32, NOP, 1);

    // Stall holds the output while pc moves; stall beats fetch
    fetch_at(1, 16'h2222, 0);
    stall = 1'b1;
    fetch_at(2, 16'h2222, 0);
    fetch_at(3, 16'h2222, 0);
    fetch_at(0, 16'h2222, 0);
    stall = 1'b0;
    fetch_at(2, 16'h3333, 0);
    tick();
    stall = 1'b1; fetch = 1'b1; pc = 0;
    tick();
    chk("stall_keeps_invalid", op_valid, 0);
    chk("stall_keeps_op", op, 16'h3333);
    stall = 1'b0; fetch = 1'b0;
    tick();

    // Reset on the second word of a five-word burst
    ld_start = 1'b1; ld_len = 5;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 16'hA0A0;
    tick();
    ld_data = 16'hA1A1; rst = 1'b1;
    tick();
    chk("abort_busy", ld_busy, 0);
    chk("abort_done", ld_done, 0);
    chk("abort_op", op, NOP);
    chk("abort_valid", op_valid, 0);
    rst = 1'b0; ld_valid = 1'b0;
    tick();
    chk("abort_no_done", ld_done, 0);
    chk("abort_idle", ld_busy, 0);
    vpat[0] = 1; dpat[0] = 16'hABCD;
    load(1, 1);
    fetch_at(0, 16'hABCD, 0);
    fetch_at(1, 16'h2222, 0);

    // Zero-length start, then ld_start ignored during LOAD
    load(0, 0);
    fetch_at(0, 16'hABCD, 0);
    ld_start = 1'b1; ld_len = 2; fetch = 1'b1; pc = 3;
    begin
      exp_t e;
      e.op = 16'h4301; e.err = 0;
      q.push_back(e);
    end
    tick();
    chk("start_busy2", ld_busy, 1);
    ld_start = 1'b1; ld_len = 5; ld_valid = 1'b1; ld_data = 16'h7777; pc = 0;
    tick();
    chk("busy_fetch_invalid", op_valid, 0);
    chk("busy_fetch_hold_op", op, 16'h4301);
    chk("restart_busy", ld_busy, 1);
    ld_start = 1'b0; ld_data = 16'h8888;
    tick();
    chk("restart_done", ld_done, 1);
    chk("restart_idle", ld_busy, 0);
    fetch = 1'b0; ld_valid = 1'b0;
    tick();
    fetch_at(0, 16'h7777, 0);
    fetch_at(1, 16'h8888, 0);
    fetch_at(2, 16'h3333, 0);

    // Over-long burst clamps to DEPTH words
    for (int c = 0; c < DEPTH; c++) begin
      vpat[c] = 1;
      dpat[c] = 16'h0100 + 16'(c);
    end
    load(40, DEPTH);
    fetch_at(31, 16'h011F, 0);
    fetch_at(0, 16'h0100, 0);
    fetch_at(32, NOP, 1);
    fetch_at(255, NOP, 1);

    tick(); tick();
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
